// File: rtl/rr_switch_allocator_pkg.sv
// Shared router definitions: allocator state encoding and mesh port indices,
// also used by the crossbar and route computation.
package rr_switch_allocator_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    localparam int PORT_L = 0;
    localparam int PORT_N = 1;
    localparam int PORT_E = 2;
    localparam int PORT_S = 3;
    localparam int PORT_W = 4;

endpackage

// File: rtl/rr_switch_allocator_rr_pick.sv
// Combinational rotate-priority picker: first set request at or after ptr_i,
// wrapping modulo N. Also used by the VC allocator.
module rr_pick #(
    parameter int N     = 5,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     onehot_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;
    logic             found;

    // Walk offsets 0..N-1 from the pointer; the first hit wins.
    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        found    = 1'b0;
        sum      = '0;
        cand     = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr_i} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(N)) begin
                sum = sum - (IDX_W+1)'(N);
            end
            cand = sum[IDX_W-1:0];
            if (!found && req_i[cand]) begin
                found          = 1'b1;
                onehot_o[cand] = 1'b1;
                idx_o          = cand;
            end
        end
    end

endmodule

// File: rtl/rr_switch_allocator.sv
// Round-robin wormhole output-port allocator with registered one-hot grant.
// Optional idle-lock watchdog enabled by defining ARB_TIMEOUT_EN.
module rr_switch_allocator
    import rr_switch_allocator_pkg::*;
#(
    parameter int N       = 5,
    parameter int IDX_W   = 3,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     tail,
    input  logic             out_ready,
    output logic [N-1:0]     grant,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    output logic             xfer,
    output logic             timeout
);

    if ((2**IDX_W) < N || TIMEOUT < 1) begin : g_bad_param
        $error("rr_switch_allocator: IDX_W too narrow for N or TIMEOUT < 1");
    end

    state_e           state_q;
    logic [N-1:0]     grant_q;
    logic [IDX_W-1:0] grant_idx_q;
    logic             grant_valid_q;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [N-1:0]     pick_onehot;
    logic [IDX_W-1:0] pick_idx;
    logic             force_rel;
    logic             rel;

    rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx)
    );

    assign xfer  = grant_valid_q & req[grant_idx_q] & out_ready;
    assign rel   = (xfer & tail[grant_idx_q]) | force_rel;
    assign ptr_d = (grant_idx_q == IDX_W'(N-1)) ? '0 : grant_idx_q + IDX_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            grant_idx_q   <= '0;
            grant_valid_q <= 1'b0;
            ptr_q         <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|req) begin
                        state_q       <= ST_LOCKED;
                        grant_q       <= pick_onehot;
                        grant_idx_q   <= pick_idx;
                        grant_valid_q <= 1'b1;
                    end
                end
                ST_LOCKED: begin
                    // Other requesters are ignored until the packet ends.
                    if (rel) begin
                        state_q       <= ST_IDLE;
                        grant_q       <= '0;
                        grant_idx_q   <= '0;
                        grant_valid_q <= 1'b0;
                        ptr_q         <= ptr_d;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             timeout_q;

    // Release on the TIMEOUT-th consecutive stalled locked cycle.
    assign force_rel = (state_q == ST_LOCKED) && !xfer &&
                       (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (state_q != ST_LOCKED || xfer || force_rel) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= force_rel;
        end
    end

    assign timeout = timeout_q;
`else
    assign force_rel = 1'b0;
    assign timeout   = 1'b0;
`endif

    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;
    assign grant_idx   = grant_idx_q;

endmodule

// File: doc/rr_switch_allocator.md
Name: rr_switch_allocator

Overview:
Parametrised round-robin output-port allocator for the mesh router; successor to the fixed-priority 5-input per-port selector. Arbitrates N input-port requests for one output port and returns a registered one-hot grant. Holds the grant for a whole wormhole packet, from grant until the tail flit transfers. Rotates priority after each packet for fairness. One instance per router output port, driving the crossbar select.

Parameters:
N, 5, number of requesting input ports (L, N, E, S, W at default)
IDX_W, 3, width of encoded grant index; must satisfy 2**IDX_W >= N
TIMEOUT, 16, idle-lock watchdog limit in cycles (used only with ARB_TIMEOUT_EN)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-low reset
req  input  N  per-input request; bit i high while input i has a flit for this output
tail  input  N  per-input tail marker; bit i qualifies the flit currently offered by input i
out_ready  input  1  downstream (output buffer) can accept a flit this cycle
grant  output  N  registered one-hot grant; all-zero when idle
grant_valid  output  1  high while a grant is held
grant_idx  output  IDX_W  binary index of the granted input; 0 when idle
xfer  output  1  combinational: grant_valid & req[grant_idx] & out_ready (flit moves this cycle)
timeout  output  1  one-cycle pulse on forced release (ARB_TIMEOUT_EN only, else tied 0)

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, grant=0, grant_valid=0, grant_idx=0, priority pointer ptr=0, timeout=0. Deassertion is synchronised externally; the block only samples rst asynchronously.
- States: IDLE, LOCKED.
- IDLE: if any req bit is set, pick the winner as the first set bit at or after ptr, scanning upward and wrapping modulo N. Register grant/grant_idx/grant_valid at the next edge and go to LOCKED. Latency is one cycle from req to grant. If req==0, stay in IDLE with outputs at zero. No X outputs under any condition.
- LOCKED: grant held constant.
  - Flit transfers when xfer=1.
  - If xfer & tail[grant_idx]: release at that edge. grant=0, grant_valid=0, ptr=(grant_idx+1) mod N (wrap from N-1 to 0), state=IDLE.
  - Minimum one bubble cycle between packets on the same output.
  - req[grant_idx] dropping while LOCKED without a tail transfer keeps the lock (wormhole semantics; upstream stall).
  - Requests from other inputs while LOCKED are ignored; they are not queued or latched.
- Single-flit packet (head = tail): grant at cycle 1; with out_ready=1 and tail=1, release at the end of cycle 1. Effective occupancy is 2 cycles including the bubble.
- out_ready low: no xfer, no release, grant held.
- Simultaneous tail release and new requests: new requests are evaluated in the following IDLE cycle against the updated ptr.
- Invalid index: ptr and grant_idx never exceed N-1. For non-power-of-2 N, out-of-range index values are unreachable.
- Reset mid-packet: lock drops immediately and asynchronously; ptr returns to 0.

Optional Feature:
ARB_TIMEOUT_EN
- Defined: a counter of width clog2(TIMEOUT+1) counts consecutive LOCKED cycles with xfer=0; it clears on any xfer and on entry to LOCKED. When it reaches TIMEOUT, the block forces a release (same actions as a tail release, ptr=grant_idx+1) and pulses timeout for one cycle. This recovers a dead or misbehaving upstream.
- Undefined: no counter; timeout is tied to 0; the lock releases only on a tail transfer.

Decomposition:
- Shared package: state encoding constants (ST_IDLE=1'b0, ST_LOCKED=1'b1) and router port-index constants (PORT_L=0, PORT_N=1, PORT_E=2, PORT_S=3, PORT_W=4), shared with the crossbar and route computation.
- One natural sub-module: rr_pick. Purely combinational N-bit rotate-priority picker with inputs req and ptr and outputs onehot and idx. Reused by the VC allocator.

Test Plan:
1. Reset, then req=5'b10110 with ptr=0 -> grant=5'b00010 and grant_idx=1 one cycle later, grant_valid=1.
2. Hold grant on input 1; 3 body flits, then tail with out_ready=1 -> release after the tail cycle, ptr=2; still-pending req=5'b10100 -> next grant 5'b00100.
3. Wrap-around: grant input 4, tail transfers -> ptr=0; req=5'b10001 -> grant 5'b00001 (input 0 wins over 4).
4. Lock hold: mid-packet, drop req[grant_idx] for 3 cycles and hold out_ready=0 for 2 more, while others request -> grant unchanged, no xfer, no release.
5. Async reset asserted mid-packet between clock edges -> grant, grant_valid and grant_idx go to 0 immediately; ptr=0 after release.
6. ARB_TIMEOUT_EN with TIMEOUT=16: lock input 3, no xfer for 16 cycles -> timeout pulses once, grant cleared, ptr=4; without the macro the grant is held indefinitely.
